time_of_day_counter: RTL

//  Free-running wall-clock generator for the traffic-light controller: counts

---
 rtl/time_of_day_counter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/time_of_day_counter.sv
// Wall-clock hours/minutes/ticks counter driven by a one-cycle tick strobe.
// Optional day/night flag outputs are enabled by the DAY_NIGHT_FLAG_EN macro.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   tickIn                one-cycle strobe per simulated second
//   loadEn                load loadHours/loadMinutes (seconds cleared)
//   loadHours[4:0]        hour to load, 0..23
//   loadMinutes[5:0]      minute to load, 0..59
//   hoursOut[4:0]         current hour 0..23
//   minutesOut[5:0]       current minute 0..59
//   secondsOut[5:0]       current tick 0..TICKS_PER_MINUTE-1
//   hourTick              pulse when the hour advances
//   dayRollover           pulse when the hour wraps 23 -> 0
//   loadErr               pulse when a load is rejected
//   dayOut                (DAY_NIGHT_FLAG_EN) 1 for hours 6..19
//   dayNightChange        (DAY_NIGHT_FLAG_EN) pulse when dayOut toggles
module time_of_day_counter #(
  parameter int TICKS_PER_MINUTE = 60,
  parameter int RESET_HOUR       = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tickIn,
  input  logic       loadEn,
  input  logic [4:0] loadHours,
  input  logic [5:0] loadMinutes,
  output logic [4:0] hoursOut,
  output logic [5:0] minutesOut,
  output logic [5:0] secondsOut,
  output logic       hourTick,
  output logic       dayRollover,
  output logic       loadErr
`ifdef DAY_NIGHT_FLAG_EN
  ,
  output logic       dayOut,
  output logic       dayNightChange
`endif
);

  localparam logic [5:0] SecMax  = 6'(TICKS_PER_MINUTE - 1);
  localparam logic [4:0] RstHour = 5'(RESET_HOUR);

  logic       loadOk;
  logic [4:0] nextHour;
  logic [5:0] nextMin;
  logic [5:0] nextSec;
  logic       nextHourTick;
  logic       nextDayRoll;
  logic       nextLoadErr;

  assign loadOk = (loadHours <= 5'd23) && (loadMinutes <= 6'd59);

  // A rejected load still blocks a coincident tick.
  always_comb begin
    nextHour     = hoursOut;
    nextMin      = minutesOut;
    nextSec      = secondsOut;
    nextHourTick = 1'b0;
    nextDayRoll  = 1'b0;
    nextLoadErr  = 1'b0;
    if (loadEn) begin
      if (loadOk) begin
        nextHour = loadHours;
        nextMin  = loadMinutes;
        nextSec  = 6'd0;
      end else begin
        nextLoadErr = 1'b1;
      end
    end else if (tickIn) begin
      if (secondsOut >= SecMax) begin
        nextSec = 6'd0;
        if (minutesOut >= 6'd59) begin
          nextMin      = 6'd0;
          nextHourTick = 1'b1;
          if (hoursOut >= 5'd23) begin
            nextHour    = 5'd0;
            nextDayRoll = 1'b1;
          end else begin
            nextHour = hoursOut + 5'd1;
          end
        end else begin
          nextMin = minutesOut + 6'd1;
        end
      end else begin
        nextSec = secondsOut + 6'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hoursOut    <= RstHour;
      minutesOut  <= 6'd0;
      secondsOut  <= 6'd0;
      hourTick    <= 1'b0;
      dayRollover <= 1'b0;
      loadErr     <= 1'b0;
    end else begin
      hoursOut    <= nextHour;
      minutesOut  <= nextMin;
      secondsOut  <= nextSec;
      hourTick    <= nextHourTick;
      dayRollover <= nextDayRoll;
      loadErr     <= nextLoadErr;
    end
  end

`ifdef DAY_NIGHT_FLAG_EN
  localparam logic RstDay =
    (RESET_HOUR >= 6) && (RESET_HOUR <= 19);

  logic nextDay;

  // Decoded from the next-state hour so the flag lines up with hoursOut.
  assign nextDay = (nextHour >= 5'd6) && (nextHour <= 5'd19);

  always_ff @(posedge clk) begin
    if (reset) begin
      dayOut         <= RstDay;
      dayNightChange <= 1'b0;
    end else begin
      dayOut         <= nextDay;
      dayNightChange <= nextDay ^ dayOut;
    end
  end
`endif

endmodule
